// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a shared single-port data memory: round-robin with
// bounded locking, misalignment trapping and a one-cycle response path.
module mem_port_arbiter #(
    parameter int Width   = 32,
    parameter int AddrW   = 12,
    parameter int MaxLock = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_req_i,
    input  logic             m0_we_i,
    input  logic             m0_lock_i,
    input  logic [AddrW-1:0] m0_addr_i,
    input  logic [Width-1:0] m0_wdata_i,
    input  logic [3:0]       m0_be_i,
    output logic             m0_gnt_o,
    output logic             m0_rvalid_o,
    output logic             m0_err_o,
    output logic [Width-1:0] m0_rdata_o,
    input  logic             m1_req_i,
    input  logic             m1_we_i,
    input  logic             m1_lock_i,
    input  logic [AddrW-1:0] m1_addr_i,
    input  logic [Width-1:0] m1_wdata_i,
    input  logic [3:0]       m1_be_i,
    output logic             m1_gnt_o,
    output logic             m1_rvalid_o,
    output logic             m1_err_o,
    output logic [Width-1:0] m1_rdata_o,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic [AddrW-1:0] mem_addr_o,
    output logic [Width-1:0] mem_wdata_o,
    output logic [3:0]       mem_be_o,
    input  logic [Width-1:0] mem_rdata_i
);

    localparam int CntW = $clog2(MaxLock) + 1;

    function automatic logic misaligned(input logic [1:0] a, input logic [3:0] be);
        case (be)
            4'b1111:          return a != 2'b00;
            4'b0011, 4'b1100: return a[0];
            4'b0000:          return 1'b1;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] c);
        return (c == CntW'(MaxLock)) ? c : c + CntW'(1);
    endfunction

    logic [1:0]       req;
    logic [1:0]       lock;
    logic             prio;
    logic             prev_vld;
    logic             prev_own;
    logic [CntW-1:0]  lock_cnt;
    logic             hold;
    logic             any_p0;
    logic             own_p0;
    logic             locked_regrant;
    logic             sel_we;
    logic [AddrW-1:0] sel_addr;
    logic [Width-1:0] sel_wdata;
    logic [3:0]       sel_be;
    logic             bad_p0;
    logic             fwd_p0;
    logic             vld_p1;
    logic             own_p1;
    logic             err_p1;
    logic             rd_p1;
    logic             live_p1;
    logic [Width-1:0] rdata_p1;

    assign req  = {m1_req_i, m0_req_i};
    assign lock = {m1_lock_i, m0_lock_i};

    // Stage p0: arbitration and forwarding in the grant cycle
    always_comb begin
        any_p0         = 1'b0;
        own_p0         = 1'b0;
        locked_regrant = 1'b0;
        hold           = prev_vld && req[prev_own] && lock[prev_own];
        if (!rst_i) begin
            any_p0 = |req;
            if (hold) begin
                // A lock that has run MaxLock re-grants yields once to a waiting peer.
                if (lock_cnt == CntW'(MaxLock) && req[~prev_own]) begin
                    own_p0 = ~prev_own;
                end else begin
                    own_p0         = prev_own;
                    locked_regrant = 1'b1;
                end
            end else if (req == 2'b11) begin
                own_p0 = prio;
            end else begin
                own_p0 = req[1];
            end
        end
    end

    assign sel_we    = own_p0 ? m1_we_i    : m0_we_i;
    assign sel_addr  = own_p0 ? m1_addr_i  : m0_addr_i;
    assign sel_wdata = own_p0 ? m1_wdata_i : m0_wdata_i;
    assign sel_be    = own_p0 ? m1_be_i    : m0_be_i;
    assign bad_p0    = misaligned(sel_addr[1:0], sel_be);
    assign fwd_p0    = any_p0 && !bad_p0;

    assign m0_gnt_o    = any_p0 && !own_p0;
    assign m1_gnt_o    = any_p0 && own_p0;
    assign mem_req_o   = fwd_p0;
    assign mem_we_o    = fwd_p0 && sel_we;
    assign mem_addr_o  = fwd_p0 ? sel_addr  : '0;
    assign mem_wdata_o = fwd_p0 ? sel_wdata : '0;
    assign mem_be_o    = fwd_p0 ? sel_be    : 4'b0000;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio     <= 1'b0;
            prev_vld <= 1'b0;
            prev_own <= 1'b0;
            lock_cnt <= '0;
            vld_p1   <= 1'b0;
            own_p1   <= 1'b0;
            err_p1   <= 1'b0;
            rd_p1    <= 1'b0;
        end else begin
            prev_vld <= any_p0;
            prev_own <= own_p0;
            if (any_p0) begin
                prio <= ~own_p0;
            end
            lock_cnt <= locked_regrant ? sat_inc(lock_cnt) : '0;
            vld_p1   <= any_p0;
            own_p1   <= own_p0;
            err_p1   <= bad_p0;
            rd_p1    <= !sel_we;
        end
    end

    // Stage p1: response to the owner one cycle after its grant
    assign live_p1  = vld_p1 && !rst_i;
    assign rdata_p1 = (live_p1 && !err_p1 && rd_p1) ? mem_rdata_i : '0;

    assign m0_rvalid_o = live_p1 && !own_p1;
    assign m0_err_o    = live_p1 && !own_p1 && err_p1;
    assign m0_rdata_o  = own_p1 ? '0 : rdata_p1;
    assign m1_rvalid_o = live_p1 && own_p1;
    assign m1_err_o    = live_p1 && own_p1 && err_p1;
    assign m1_rdata_o  = own_p1 ? rdata_p1 : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: each step drives inputs just after a
// rising edge and checks outputs mid-cycle against hand-computed values.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
    logic [11:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.Width(32), .AddrW(12), .MaxLock(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_lock_i(m0_lock), .m0_addr_i(m0_addr),
        .m0_wdata_i(m0_wdata), .m0_be_i(m0_be), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
        .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_lock_i(m1_lock), .m1_addr_i(m1_addr),
        .m1_wdata_i(m1_wdata), .m1_be_i(m1_be), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
        .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_req = 0; m0_we = 0; m0_lock = 0; m0_addr = '0; m0_wdata = '0; m0_be = 4'hF;
        m1_req = 0; m1_we = 0; m1_lock = 0; m1_addr = '0; m1_wdata = '0; m1_be = 4'hF;
    endtask

    task automatic drv0(input logic we, input logic lk, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        m0_req = 1; m0_we = we; m0_lock = lk; m0_addr = a; m0_wdata = d; m0_be = be;
    endtask

    task automatic drv1(input logic we, input logic lk, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        m1_req = 1; m1_we = we; m1_lock = lk; m1_addr = a; m1_wdata = d; m1_be = be;
    endtask

    initial begin
        idle_all();
        mem_rdata = '0;
        rst = 1;
        step();
        // Requests during reset are ignored
        drv0(1, 0, 12'h010, 32'h1, 4'hF);
        drv1(1, 0, 12'h020, 32'h2, 4'hF);
        #2;
        chk("rst_gnt0", m0_gnt, 0);
        chk("rst_gnt1", m1_gnt, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        step();
        rst = 0;
        idle_all();
        #2;
        chk("post_rst_rvalid0", m0_rvalid, 0);
        chk("post_rst_rvalid1", m1_rvalid, 0);
        chk("post_rst_rdata0", m0_rdata, 0);

        // Single read from m0
        step();
        drv0(0, 0, 12'h010, 32'h0, 4'hF);
        #2;
        chk("rd_gnt0", m0_gnt, 1);
        chk("rd_gnt1", m1_gnt, 0);
        chk("rd_mem_req", mem_req, 1);
        chk("rd_mem_addr", mem_addr, 12'h010);
        chk("rd_mem_we", mem_we, 0);
        step();
        idle_all();
        mem_rdata = 32'hDEADBEEF;
        #2;
        chk("rd_rvalid0", m0_rvalid, 1);
        chk("rd_rdata0", m0_rdata, 32'hDEADBEEF);
        chk("rd_err0", m0_err, 0);
        chk("rd_m1_quiet", {m1_gnt, m1_rvalid, m1_err, m1_rdata}, 0);

        // Round-robin after a fresh reset
        step();
        rst = 1;
        step();
        rst = 0;
        for (int k = 0; k < 4; k++) begin
            drv0(0, 0, 12'h020, 32'h0, 4'hF);
            drv1(0, 0, 12'h030, 32'h0, 4'hF);
            mem_rdata = 32'hA0000000 + k;
            #2;
            chk("rr_gnt0", m0_gnt, (k % 2) == 0);
            chk("rr_gnt1", m1_gnt, (k % 2) == 1);
            chk("rr_addr", mem_addr, (k % 2) ? 12'h030 : 12'h020);
            if (k > 0) begin
                chk("rr_rvalid0", m0_rvalid, ((k - 1) % 2) == 0);
                chk("rr_rvalid1", m1_rvalid, ((k - 1) % 2) == 1);
                chk("rr_rdata", ((k - 1) % 2) ? m1_rdata : m0_rdata, 32'hA0000000 + k);
            end
            step();
        end
        idle_all();
        mem_rdata = 32'hA0000004;
        #2;
        chk("rr_last_rvalid1", m1_rvalid, 1);
        chk("rr_last_rdata1", m1_rdata, 32'hA0000004);
        chk("rr_last_rvalid0", m0_rvalid, 0);

        // Reset right after a grant drops the pending response
        step();
        drv0(0, 0, 12'h040, 32'h0, 4'hF);
        #2;
        chk("rr_rst_gnt0", m0_gnt, 1);
        step();
        rst = 1;
        drv1(0, 0, 12'h050, 32'h0, 4'hF);
        mem_rdata = 32'h12345678;
        #2;
        chk("rst_drop_rvalid0", m0_rvalid, 0);
        chk("rst_drop_rdata0", m0_rdata, 0);
        chk("rst_drop_gnt", {m0_gnt, m1_gnt, mem_req}, 0);
        step();
        rst = 0;
        #2;
        chk("rst_after_rvalid0", m0_rvalid, 0);
        chk("rst_after_gnt0", m0_gnt, 1);
        chk("rst_after_gnt1", m1_gnt, 0);
        step();
        idle_all();
        step();

        // Misaligned word write is trapped
        drv0(1, 0, 12'h102, 32'hCAFEF00D, 4'b1111);
        #2;
        chk("mis_gnt0", m0_gnt, 1);
        chk("mis_mem_req", mem_req, 0);
        chk("mis_mem_we", mem_we, 0);
        step();
        idle_all();
        mem_rdata = 32'hFFFFFFFF;
        #2;
        chk("mis_rvalid0", m0_rvalid, 1);
        chk("mis_err0", m0_err, 1);
        chk("mis_rdata0", m0_rdata, 0);

        // Misaligned halfword read from m1
        step();
        drv1(0, 0, 12'h101, 32'h0, 4'b1100);
        #2;
        chk("mish_gnt1", m1_gnt, 1);
        chk("mish_mem_req", mem_req, 0);
        step();
        idle_all();
        #2;
        chk("mish_err1", {m1_rvalid, m1_err, m1_rdata}, {2'b11, 32'h0});

        // Byte write from m1
        step();
        drv1(1, 0, 12'h482, 32'h00AB0000, 4'b0100);
        #2;
        chk("sb_gnt1", m1_gnt, 1);
        chk("sb_mem_req", mem_req, 1);
        chk("sb_mem_be", mem_be, 4'b0100);
        chk("sb_mem_addr", mem_addr, 12'h482);
        chk("sb_mem_we", mem_we, 1);
        chk("sb_mem_wdata", mem_wdata, 32'h00AB0000);
        step();
        idle_all();
        #2;
        chk("sb_ack", {m1_rvalid, m1_err, m1_rdata}, {2'b10, 32'h0});
        chk("sb_m0_quiet", m0_rvalid, 0);

        // Lock: 17 grants to m1, one forced grant to m0, then m1 again
        step();
        drv1(0, 1, 12'h200, 32'h0, 4'hF);
        #2;
        chk("lk_first_gnt1", m1_gnt, 1);
        step();
        drv0(0, 0, 12'h204, 32'h0, 4'hF);
        for (int c = 1; c <= 16; c++) begin
            #2;
            chk("lk_hold_gnt", {m0_gnt, m1_gnt}, 2'b01);
            step();
        end
        #2;
        chk("lk_forced_gnt", {m0_gnt, m1_gnt}, 2'b10);
        chk("lk_forced_addr", mem_addr, 12'h204);
        step();
        #2;
        chk("lk_resume_gnt", {m0_gnt, m1_gnt}, 2'b01);
        chk("lk_resume_rvalid0", m0_rvalid, 1);
        step();
        idle_all();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
